// File: rtl/sprdma_if.sv
// sprdma_if: snooped CPU bus plus the DMA's drive onto the cpumc address/data mux.
// master = DMA side, slave = the CPU/memory-controller side it sits between.
interface sprdma_if;
   logic [15:0] cpu_a;
   logic        cpu_r_nw;
   logic [7:0]  cpu_dout;
   logic [7:0]  cpumc_dout;
   logic        pause;
   logic        active;
   logic [15:0] cpumc_a;
   logic        cpumc_r_nw;
   logic [7:0]  cpumc_din;

   modport master (
      input  cpu_a, cpu_r_nw, cpu_dout, cpumc_dout, pause,
      output active, cpumc_a, cpumc_r_nw, cpumc_din
   );
   modport slave (
      output cpu_a, cpu_r_nw, cpu_dout, cpumc_dout, pause,
      input  active, cpumc_a, cpumc_r_nw, cpumc_din
   );
endinterface

// File: rtl/sprdma.sv
// sprdma: on a CPU write to DMA_REG, copies page {P,00..FF} to OAM_DATA at 2 cycles/byte (513 active cycles);
// pause stalls only at byte boundaries. `SPRDMA_ODD_ALIGN_EN adds one ALIGN cycle when started on odd parity.
module sprdma #(
   parameter logic [15:0] DMA_REG  = 16'h4014,
   parameter logic [15:0] OAM_DATA = 16'h2004
) (
   input logic      clk,
   input logic      rst,
   sprdma_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_READ  = 3'd2,
      S_WRITE = 3'd3,
      S_HOLD  = 3'd4
`ifdef SPRDMA_ODD_ALIGN_EN
      , S_ALIGN = 3'd5
`endif
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] data_q, data_d;
   logic       trig;

   assign trig = !bus.cpu_r_nw && (bus.cpu_a == DMA_REG);

`ifdef SPRDMA_ODD_ALIGN_EN
   logic parity_q;

   always_ff @(posedge clk) begin
      if (rst) parity_q <= 1'b0;
      else     parity_q <= ~parity_q;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         page_q  <= 8'h00;
         cnt_q   <= 8'h00;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   // HOLD is the post-WRITE pause: the byte is done, the next READ waits for pause to drop.
   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (trig) begin
               state_d = S_START;
               page_d  = bus.cpu_dout;
               cnt_d   = 8'h00;
            end
         end
         S_START: begin
            if (!bus.pause) begin
`ifdef SPRDMA_ODD_ALIGN_EN
               state_d = parity_q ? S_ALIGN : S_READ;
`else
               state_d = S_READ;
`endif
            end
         end
`ifdef SPRDMA_ODD_ALIGN_EN
         S_ALIGN: if (!bus.pause) state_d = S_READ;
`endif
         S_READ:  state_d = S_WRITE;
         S_WRITE: begin
            data_d = bus.cpumc_dout;
            if (cnt_q == 8'hFF) begin
               state_d = S_IDLE;
            end else begin
               cnt_d   = cnt_q + 8'd1;
               state_d = bus.pause ? S_HOLD : S_READ;
            end
         end
         S_HOLD:  if (!bus.pause) state_d = S_READ;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.active     = 1'b1;
      bus.cpumc_a    = {page_q, cnt_q};
      bus.cpumc_r_nw = 1'b1;
      bus.cpumc_din  = data_q;
      case (state_q)
         S_IDLE: begin
            bus.active    = 1'b0;
            bus.cpumc_a   = 16'h0000;
            bus.cpumc_din = 8'h00;
         end
         S_START: if (!bus.pause) bus.cpumc_a = OAM_DATA;
`ifdef SPRDMA_ODD_ALIGN_EN
         S_ALIGN: if (!bus.pause) bus.cpumc_a = OAM_DATA;
`endif
         S_WRITE: begin
            bus.cpumc_a    = OAM_DATA;
            bus.cpumc_r_nw = 1'b0;
            bus.cpumc_din  = bus.cpumc_dout;
         end
         default: ;
      endcase
   end

endmodule
